// File: rtl/adder_pkg.sv
// adder_pkg: shared state encodings and beat width for the sum accumulator
package adder_pkg;
  localparam int BEAT_W = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sum_acc_ctrl.sv
// sum_acc_ctrl: frame FSM and beat counter steering the accumulator datapath
module sum_acc_ctrl
  import adder_pkg::*;
#(
  parameter int NUM_OPS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  input  logic flush,
  output logic in_ready,
  output logic out_valid,
  output logic start,
  output logic add,
  output logic clr
);
  localparam int CNT_W = $clog2(NUM_OPS + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, first;
  assign in_ready = !rst && (state_q != DONE || out_ready);
  assign accept = in_valid && in_ready;
  // a beat taken outside ACCUM always opens a new frame, giving back-to-back frames from DONE
  assign first = accept && state_q != ACCUM;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (first) begin
      cnt_d = CNT_W'(1);
      state_d = (NUM_OPS == 1) ? DONE : ACCUM;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_d == CNT_W'(NUM_OPS)) ? DONE : ACCUM;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  always_comb begin
    out_valid = state_q == DONE;
    start = !flush && first;
    add = !flush && accept && state_q == ACCUM;
    clr = flush || (state_q == DONE && out_ready && !accept);
  end
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums NUM_OPS {carry,sum} beats per frame with sticky overflow
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int NUM_OPS = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sum,
  input  logic             carry,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  logic start, add, clr;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic [ACC_W:0] total;
  sum_acc_ctrl #(.NUM_OPS(NUM_OPS)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .out_ready(out_ready),
    .flush(flush),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .start(start),
    .add(add),
    .clr(clr)
  );
  // the extra top bit of total is the carry out that marks overflow
  assign total = {1'b0, acc_q} + {{(ACC_W + 1 - BEAT_W){1'b0}}, carry, sum};
  always_comb begin
    acc_d = clr ? '0 : start ? {{(ACC_W - BEAT_W){1'b0}}, carry, sum} : add ? total[ACC_W-1:0] : acc_q;
    ovf_d = (clr || start) ? 1'b0 : add ? (ovf_q || total[ACC_W]) : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
  assign acc_out = acc_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: three accumulator configurations checked against a frame-level model
module tb_sum_accumulator;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0, carry = 0;
  logic [3:0] sum = 0;
  logic ir[3], ovl[3], ovf[3];
  logic [7:0] ao8;
  logic [5:0] ao6;
  logic [15:0] ao16;
  int errs = 0, checks = 0;
  int tot[3] = '{0, 0, 0};
  int cnt[3] = '{0, 0, 0};
  bit done[3] = '{0, 0, 0};
  int nops[3] = '{4, 4, 1};
  int w[3] = '{8, 6, 16};
  sum_accumulator #(.NUM_OPS(4), .ACC_W(8)) u8 (
    .clk(clk), .rst(rst), .sum(sum), .carry(carry), .in_valid(in_valid), .in_ready(ir[0]),
    .flush(flush), .acc_out(ao8), .ovf(ovf[0]), .out_valid(ovl[0]), .out_ready(out_ready));
  sum_accumulator #(.NUM_OPS(4), .ACC_W(6)) u6 (
    .clk(clk), .rst(rst), .sum(sum), .carry(carry), .in_valid(in_valid), .in_ready(ir[1]),
    .flush(flush), .acc_out(ao6), .ovf(ovf[1]), .out_valid(ovl[1]), .out_ready(out_ready));
  sum_accumulator #(.NUM_OPS(1), .ACC_W(16)) u1 (
    .clk(clk), .rst(rst), .sum(sum), .carry(carry), .in_valid(in_valid), .in_ready(ir[2]),
    .flush(flush), .acc_out(ao16), .ovf(ovf[2]), .out_valid(ovl[2]), .out_ready(out_ready));
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // model: a frame is the running true total of its beats; done once it holds NUM_OPS beats
  task automatic cyc(bit r, bit v, bit f, bit o, logic [4:0] b);
    @(negedge clk);
    rst = r; in_valid = v; flush = f; out_ready = o; {carry, sum} = b;
    #1;
    for (int i = 0; i < 3; i++) begin
      int a;
      bit acc;
      a = (i == 0) ? int'(ao8) : (i == 1) ? int'(ao6) : int'(ao16);
      check($sformatf("u%0d in_ready", i), int'(ir[i]), r ? 0 : int'(!done[i] || o));
      check($sformatf("u%0d out_valid", i), int'(ovl[i]), int'(done[i]));
      check($sformatf("u%0d acc_out", i), a, tot[i] % (1 << w[i]));
      check($sformatf("u%0d ovf", i), int'(ovf[i]), int'(tot[i] > (1 << w[i]) - 1));
      acc = v && (!done[i] || o);
      if (r || f) begin
        tot[i] = 0; cnt[i] = 0; done[i] = 0;
      end else begin
        if (done[i] && o) begin
          tot[i] = 0; cnt[i] = 0; done[i] = 0;
        end
        if (acc) begin
          tot[i] += int'(b); cnt[i]++; done[i] = cnt[i] == nops[i];
        end
      end
    end
    @(posedge clk);
  endtask
  function automatic logic [4:0] rb();
    return 5'($urandom_range(0, 31));
  endfunction
  initial begin
    int s;
    logic [4:0] b;
    repeat (2) @(posedge clk);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 5'b01101);
    cyc(0, 1, 0, 1, 5'b10001);
    cyc(0, 1, 0, 1, 5'b10001);
    cyc(0, 1, 0, 1, 5'b00101);
    #1;
    check("s1 valid", int'(ovl[0]), 1);
    check("s1 acc", int'(ao8), 52);
    check("s1 ovf", int'(ovf[0]), 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (4) cyc(0, 1, 0, 1, 5'd31);
    #1;
    check("s2 acc6", int'(ao6), 60);
    check("s2 ovf6", int'(ovf[1]), 1);
    check("s2 acc8", int'(ao8), 124);
    check("s2 ovf8", int'(ovf[0]), 0);
    cyc(0, 0, 0, 1, 0);
    repeat (4) cyc(0, 1, 0, 1, rb());
    repeat (5) cyc(0, 1, 0, 0, rb());
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    s = 0;
    for (int k = 0; k < 8; k++) begin
      b = rb();
      if (k >= 4) s += int'(b);
      cyc(0, 1, 0, 1, b);
    end
    #1;
    check("s4 valid", int'(ovl[0]), 1);
    check("s4 acc", int'(ao8), s);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, rb());
    cyc(0, 1, 0, 1, rb());
    cyc(0, 1, 1, 1, rb());
    #1;
    check("s5 flush acc", int'(ao8), 0);
    s = 0;
    for (int k = 0; k < 4; k++) begin
      b = rb();
      s += int'(b);
      cyc(0, 1, 0, 1, b);
    end
    #1;
    check("s5 fresh acc", int'(ao8), s);
    cyc(0, 1, 0, 1, rb());
    cyc(0, 1, 0, 1, rb());
    cyc(1, 0, 0, 1, 0);
    #1;
    check("s6 mid acc", int'(ao8), 0);
    repeat (4) cyc(0, 1, 0, 1, rb());
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, rb());
    #1;
    check("s6 done valid", int'(ovl[0]), 0);
    cyc(0, 1, 0, 1, rb());
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
          $urandom_range(0, 9) < 7, rb());
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
